dma_controller: RTL
===================

Name: dma_controller

Overview:
- Single-channel DMA controller; the direct counterpart of the CPU bus-arbitration FSM.
- Consumes the CPU's drq and start_transfer (hold acknowledge).
- Produces hrq, dack and transfer_done back to the CPU.
- While the CPU holds off the bus, copies a block of words from a source address to a destination address over a simple synchronous memory port.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 8, memory data width.
- LEN_W, 8, width of the transfer-length field (max LEN = 2^LEN_W-1 words).
- GRANT_TIMEOUT, 255, cycles to wait for start_transfer before abort (optional feature only).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- drq  in  1  DMA request from CPU (level)
- start_transfer  in  1  hold acknowledge / bus grant from CPU (level)
- hrq  out  1  hold request to CPU
- dack  out  1  DMA acknowledge; high while words are being moved
- transfer_done  out  1  one-cycle completion pulse
- cfg_src  in  ADDR_W  source start address
- cfg_dst  in  ADDR_W  destination start address
- cfg_len  in  LEN_W  number of words to move
- mem_addr  out  ADDR_W  memory address
- mem_rd_en  out  1  memory read strobe
- mem_wr_en  out  1  memory write strobe
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data; valid the cycle after mem_rd_en

Behaviour:
- All outputs registered. On rst, all outputs are 0, internal counters/registers are 0, and state = IDLE.
- rst asserted mid-transfer aborts immediately: no transfer_done pulse, memory strobes drop on the same edge.
- States: IDLE, HOLD_REQ, READ, READ_WAIT, WRITE, DONE.
- IDLE:
  - drq=1 at an edge: latch cfg_src/cfg_dst/cfg_len into src_ptr/dst_ptr/remaining; set hrq=1; go HOLD_REQ.
  - cfg_* changes after latch are ignored until the next IDLE.
- HOLD_REQ:
  - hrq held 1; wait for start_transfer=1.
  - On grant with remaining=0: go DONE directly (zero-length transfer, no memory access).
  - On grant otherwise: dack=1, go READ.
  - drq dropping in HOLD_REQ does not cancel; the request completes.
- READ (1 cycle): mem_rd_en=1, mem_addr=src_ptr.
- READ_WAIT (1 cycle): strobes 0.
- WRITE (1 cycle):
  - At entry, capture mem_rdata into the data register; mem_wr_en=1, mem_addr=dst_ptr, mem_wdata=captured value.
  - On leaving WRITE: src_ptr+1, dst_ptr+1, remaining-1. Pointers wrap modulo 2^ADDR_W.
  - remaining reaches 0: go DONE; otherwise go READ.
- Throughput: exactly 3 cycles per word.
- DONE (1 cycle): transfer_done=1, hrq=0, dack=0, strobes 0; go IDLE.
- Timing: with grant sampled at edge M and LEN=L>0, transfer_done is high in the cycle following edge M+3L.
- mem_rd_en and mem_wr_en are never asserted in the same cycle, and are never asserted outside READ/WRITE.
- start_transfer may stay high permanently (the CPU does not clear it). It is only sampled in HOLD_REQ, so a held grant means the next request proceeds on the first HOLD_REQ cycle.
- drq still high in the IDLE cycle after DONE starts a new transfer (back-to-back transfers allowed).

Optional Feature:
- Macro: DMA_GRANT_TIMEOUT_EN.
- With the macro defined:
  - A counter runs in HOLD_REQ.
  - If start_transfer is not seen within GRANT_TIMEOUT cycles, hrq drops and the block returns to IDLE.
  - An extra output port dma_err (1 bit) pulses for one cycle; transfer_done is not pulsed.
  - Counter clears on entry to HOLD_REQ.
- Without the macro: no counter, no dma_err port; HOLD_REQ waits indefinitely.

Test Plan:
- Reset then idle, drq=0 for 20 cycles -> hrq, dack, transfer_done, mem_rd_en, mem_wr_en all stay 0.
- Single transfer: src=0x0010, dst=0x0100, len=4, memory preloaded 0xA0..0xA3, grant 2 cycles after hrq -> 4 reads at 0x10..0x13, 4 writes of 0xA0..0xA3 at 0x100..0x103, 12 active cycles, one transfer_done pulse, hrq/dack low afterwards.
- Zero length: len=0 with grant -> transfer_done pulses one cycle after grant; no memory strobes.
- Wrap: src=0xFFFE, dst=0x0000, len=3 -> reads at 0xFFFE, 0xFFFF, 0x0000.
- Back-to-back: drq held high, start_transfer held high, len=2 -> transfer_done pulses, IDLE for one cycle, hrq re-asserts and the second transfer completes with fresh cfg values.
- Reset mid-transfer after word 2 of len=5 -> all outputs 0 next cycle, no transfer_done; with DMA_GRANT_TIMEOUT_EN and GRANT_TIMEOUT=10 and no grant -> dma_err pulse 10 cycles after HOLD_REQ entry, hrq=0.

Source files
------------

// File: rtl/dma_controller.sv
// -----------------------------------------------------------------------------
// dma_controller
// -----------------------------------------------------------------------------
// Single-channel block-copy DMA engine. It is the bus-side partner of the CPU
// arbitration FSM. The CPU raises drq. The engine latches the source,
// destination and length, requests the bus with hrq, and waits for the hold
// acknowledge (start_transfer). It then copies the block one word at a time
// over a simple synchronous memory port. Each word takes three cycles:
// read, wait and write. transfer_done pulses once the last word is written.
//
// Optional feature (macro DMA_GRANT_TIMEOUT_EN):
//   When the macro is defined, the engine counts cycles spent in HOLD_REQ.
//   If no grant arrives within GRANT_TIMEOUT cycles, the engine drops hrq,
//   returns to IDLE and pulses dma_err for one cycle. The dma_err port exists
//   only in that build. Without the macro, HOLD_REQ waits indefinitely.
//
// Ports:
//   clk             in   1       system clock, rising edge
//   rst             in   1       synchronous, active-high reset
//   drq             in   1       DMA request from CPU (level)
//   start_transfer  in   1       hold acknowledge / bus grant from CPU (level)
//   hrq             out  1       hold request to CPU
//   dack            out  1       DMA acknowledge, high while words are moved
//   transfer_done   out  1       one-cycle completion pulse
//   cfg_src         in   ADDR_W  source start address
//   cfg_dst         in   ADDR_W  destination start address
//   cfg_len         in   LEN_W   number of words to move
//   mem_addr        out  ADDR_W  memory address
//   mem_rd_en       out  1       memory read strobe
//   mem_wr_en       out  1       memory write strobe
//   mem_wdata       out  DATA_W  memory write data
//   mem_rdata       in   DATA_W  memory read data, valid the cycle after
//                                mem_rd_en
//   dma_err         out  1       grant-timeout pulse (DMA_GRANT_TIMEOUT_EN only)
//
// Every output is a flop. The next-state logic also computes the output
// values for the state being entered. As a result, each output reflects the
// current state in the same cycle without any combinational decode at the
// pins.
// -----------------------------------------------------------------------------
module dma_controller #(
   parameter int ADDR_W        = 16,
   parameter int DATA_W        = 8,
   parameter int LEN_W         = 8,
   parameter int GRANT_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              drq,
   input  logic              start_transfer,
   output logic              hrq,
   output logic              dack,
   output logic              transfer_done,
   input  logic [ADDR_W-1:0] cfg_src,
   input  logic [ADDR_W-1:0] cfg_dst,
   input  logic [LEN_W-1:0]  cfg_len,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   output logic              mem_wr_en,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef DMA_GRANT_TIMEOUT_EN
   ,
   output logic              dma_err
`endif
);

   typedef enum logic [2:0] {
      IDLE,
      HOLD_REQ,
      READ,
      READ_WAIT,
      WRITE,
      DONE
   } state_t;

   state_t            state, state_nxt;

   // Transfer context, latched from cfg_* when a request is accepted.
   logic [ADDR_W-1:0] src_ptr, src_nxt;
   logic [ADDR_W-1:0] dst_ptr, dst_nxt;
   logic [LEN_W-1:0]  remaining, rem_nxt;

   // Word in flight between READ_WAIT and WRITE. It drives mem_wdata directly.
   logic [DATA_W-1:0] data_q;
   logic              load_data;

   // Output values for the state being entered.
   logic              hrq_nxt;
   logic              dack_nxt;
   logic              done_nxt;
   logic              rd_nxt;
   logic              wr_nxt;
   logic [ADDR_W-1:0] addr_nxt;

`ifdef DMA_GRANT_TIMEOUT_EN
   // The counter holds 0 .. GRANT_TIMEOUT-1. The last value is the final
   // cycle in which a grant is still accepted.
   localparam int CNT_W = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;

   logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
   logic              timeout_nxt;
`endif

   assign mem_wdata = data_q;

   // --------------------------------------------------------------------------
   // Next-state and next-output logic
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first, so that no path
      // leaves a value unassigned and infers a latch.
      state_nxt = state;
      src_nxt   = src_ptr;
      dst_nxt   = dst_ptr;
      rem_nxt   = remaining;
      load_data = 1'b0;
`ifdef DMA_GRANT_TIMEOUT_EN
      wait_cnt_nxt = wait_cnt;
      timeout_nxt  = 1'b0;
`endif

      case (state)
         IDLE: begin
            // Latch the request. Later cfg_* changes are ignored until the
            // next time the engine is in IDLE.
            if (drq) begin
               src_nxt   = cfg_src;
               dst_nxt   = cfg_dst;
               rem_nxt   = cfg_len;
               state_nxt = HOLD_REQ;
`ifdef DMA_GRANT_TIMEOUT_EN
               wait_cnt_nxt = '0;
`endif
            end
         end

         HOLD_REQ: begin
            // drq is not looked at here. Once accepted, a request always
            // finishes.
            if (start_transfer) begin
               state_nxt = (remaining == '0) ? DONE : READ;
            end
`ifdef DMA_GRANT_TIMEOUT_EN
            else if (wait_cnt == CNT_W'(GRANT_TIMEOUT - 1)) begin
               state_nxt   = IDLE;
               timeout_nxt = 1'b1;
            end else begin
               wait_cnt_nxt = wait_cnt + CNT_W'(1);
            end
`endif
         end

         READ: begin
            state_nxt = READ_WAIT;
         end

         READ_WAIT: begin
            // mem_rdata answers the READ strobe in this cycle. It is captured
            // on the edge that enters WRITE.
            load_data = 1'b1;
            state_nxt = WRITE;
         end

         WRITE: begin
            // Pointers wrap naturally at 2^ADDR_W.
            src_nxt   = src_ptr + ADDR_W'(1);
            dst_nxt   = dst_ptr + ADDR_W'(1);
            rem_nxt   = remaining - LEN_W'(1);
            state_nxt = (remaining == LEN_W'(1)) ? DONE : READ;
         end

         DONE: begin
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Moore-style outputs, taken from the state being entered and
      // registered below.
      hrq_nxt  = (state_nxt == HOLD_REQ) || (state_nxt == READ) ||
                 (state_nxt == READ_WAIT) || (state_nxt == WRITE);
      dack_nxt = (state_nxt == READ) || (state_nxt == READ_WAIT) ||
                 (state_nxt == WRITE);
      done_nxt = (state_nxt == DONE);
      rd_nxt   = (state_nxt == READ);
      wr_nxt   = (state_nxt == WRITE);

      // On WRITE -> READ the read address is the pointer value that is being
      // incremented on this same edge, so use the *_nxt pointers.
      addr_nxt = '0;
      if (state_nxt == READ) begin
         addr_nxt = src_nxt;
      end else if (state_nxt == WRITE) begin
         addr_nxt = dst_nxt;
      end
   end

   // --------------------------------------------------------------------------
   // State, context and output registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only. Every flop
      // then samples the values from before the edge, whatever order the
      // statements appear in.
      if (rst) begin
         state         <= IDLE;
         src_ptr       <= '0;
         dst_ptr       <= '0;
         remaining     <= '0;
         // NOTE: the data register is reset with the rest of the datapath.
         // mem_wdata is an output, and every output must read 0 after reset.
         data_q        <= '0;
         hrq           <= 1'b0;
         dack          <= 1'b0;
         transfer_done <= 1'b0;
         mem_rd_en     <= 1'b0;
         mem_wr_en     <= 1'b0;
         mem_addr      <= '0;
`ifdef DMA_GRANT_TIMEOUT_EN
         wait_cnt      <= '0;
         dma_err       <= 1'b0;
`endif
      end else begin
         state         <= state_nxt;
         src_ptr       <= src_nxt;
         dst_ptr       <= dst_nxt;
         remaining     <= rem_nxt;
         if (load_data) begin
            data_q <= mem_rdata;
         end
         hrq           <= hrq_nxt;
         dack          <= dack_nxt;
         transfer_done <= done_nxt;
         mem_rd_en     <= rd_nxt;
         mem_wr_en     <= wr_nxt;
         mem_addr      <= addr_nxt;
`ifdef DMA_GRANT_TIMEOUT_EN
         wait_cnt      <= wait_cnt_nxt;
         dma_err       <= timeout_nxt;
`endif
      end
   end

   // --------------------------------------------------------------------------
   // Protocol properties
   // --------------------------------------------------------------------------
   a_timeout_cfg: assert property (@(posedge clk) GRANT_TIMEOUT >= 1);

   a_strobe_exclusive: assert property (@(posedge clk) disable iff (rst)
      !(mem_rd_en && mem_wr_en));

   a_rd_only_in_read: assert property (@(posedge clk) disable iff (rst)
      mem_rd_en |-> (state == READ));

   a_wr_only_in_write: assert property (@(posedge clk) disable iff (rst)
      mem_wr_en |-> (state == WRITE));

   a_done_single_pulse: assert property (@(posedge clk) disable iff (rst)
      transfer_done |=> !transfer_done);

   a_done_releases_bus: assert property (@(posedge clk) disable iff (rst)
      transfer_done |-> (!hrq && !dack));

endmodule
